// File: rtl/obstacle_engine_if.sv
// obstacle_engine_if: tick/button/hit inputs and player/wall/status outputs of the game core
interface obstacle_engine_if #(
  parameter int N_WALLS = 2,
  parameter int W       = 11
);
  logic                 tick;
  logic                 btn_up;
  logic                 btn_down;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_centre;
  logic                 hit;
  logic [W-1:0]         blk_x;
  logic [W-1:0]         blk_y;
  logic [N_WALLS*W-1:0] wall_x;
  logic [N_WALLS*W-1:0] gap_y;
  logic [W-1:0]         gap_size;
  logic                 stop;
  logic                 score_clr;
  logic [1:0]           state;
  modport master (
    output tick, btn_up, btn_down, btn_left, btn_right, btn_centre, hit,
    input  blk_x, blk_y, wall_x, gap_y, gap_size, stop, score_clr, state
  );
  modport slave (
    input  tick, btn_up, btn_down, btn_left, btn_right, btn_centre, hit,
    output blk_x, blk_y, wall_x, gap_y, gap_size, stop, score_clr, state
  );
endinterface

// File: rtl/obstacle_engine.sv
// obstacle_engine: dodge-game core (player, N scrolling walls, hit latch, death/respawn FSM); WALL_SPEEDUP_EN adds wall acceleration
module obstacle_engine #(
  parameter int N_WALLS     = 2,
  parameter int W           = 11,
  parameter int SCREEN_W    = 1440,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 1396,
  parameter int Y_MIN       = 14,
  parameter int Y_MAX       = 856,
  parameter int X_START     = 704,
  parameter int Y_START     = 435,
  parameter int PLAYER_STEP = 3,
  parameter int WALL_STEP   = 4,
  parameter int GAP_INIT    = 150,
  parameter int GAP_MIN     = 45,
  parameter int GAP_DEC     = 10,
  parameter int GAP_MARGIN  = 64,
  parameter int GAP_MASK    = 511,
  parameter int DEAD_TICKS  = 400
) (
  input logic              clk,
  input logic              reset_n,
  obstacle_engine_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;
  localparam int CW = $clog2(DEAD_TICKS + 1);
  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d, gs_q, gs_d, px, py, step, new_gap;
  logic [W-1:0]   wx_q [N_WALLS];
  logic [W-1:0]   wx_d [N_WALLS];
  logic [W-1:0]   gy_q [N_WALLS];
  logic [W-1:0]   gy_d [N_WALLS];
  logic [W-1:0]   wx_mv [N_WALLS];
  logic [W-1:0]   gy_mv [N_WALLS];
  logic [W-1:0]   wx_rst [N_WALLS];
  logic [W-1:0]   gy_rst [N_WALLS];
  logic [15:0]    lfsr_q, lfsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           hit_q, hit_d, clr_q, clr_d, hit_now, wrap, shrink;
`ifdef WALL_SPEEDUP_EN
  logic [W-1:0]   spd_q, spd_d;
  assign step = spd_q;
`else
  assign step = W'(WALL_STEP);
`endif
  assign hit_now = hit_q | bus_io.hit;
  assign px = (bus_io.btn_right && !bus_io.btn_left && x_q < W'(X_MAX)) ? x_q + W'(PLAYER_STEP) :
              (bus_io.btn_left && !bus_io.btn_right && x_q > W'(X_MIN)) ? x_q - W'(PLAYER_STEP) : x_q;
  assign py = (bus_io.btn_down && !bus_io.btn_up && y_q < W'(Y_MAX)) ? y_q + W'(PLAYER_STEP) :
              (bus_io.btn_up && !bus_io.btn_down && y_q > W'(Y_MIN)) ? y_q - W'(PLAYER_STEP) : y_q;
  // spawn layout: walls evenly spaced across the screen, gaps staggered by 64
  always_comb begin
    for (int i = 0; i < N_WALLS; i++) begin
      wx_rst[i] = W'(i * (SCREEN_W / N_WALLS));
      gy_rst[i] = W'(GAP_MARGIN + i * 64);
    end
  end
  // scroll candidates; a wrapping wall takes a fresh gap from the current lfsr value
  always_comb begin
    new_gap = W'(GAP_MARGIN) + W'(lfsr_q & 16'(GAP_MASK));
    wrap = 1'b0;
    for (int i = 0; i < N_WALLS; i++) begin
      wx_mv[i] = wx_q[i] + step;
      gy_mv[i] = gy_q[i];
      if ({1'b0, wx_q[i]} + {1'b0, step} >= (W+1)'(SCREEN_W)) begin
        wx_mv[i] = '0;
        gy_mv[i] = new_gap;
        wrap = 1'b1;
      end
    end
    shrink = wrap && gs_q > W'(GAP_MIN);
  end
  // next-state: hit latch every cycle, everything else only on tick
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    wx_d = wx_q;
    gy_d = gy_q;
    gs_d = gs_q;
    cnt_d = cnt_q;
    lfsr_d = lfsr_q;
    clr_d = 1'b0;
    hit_d = hit_now;
`ifdef WALL_SPEEDUP_EN
    spd_d = spd_q;
`endif
    if (bus_io.tick) begin
      hit_d = 1'b0;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (state_q)
        IDLE: if (bus_io.btn_centre) begin
          state_d = PLAY;
          clr_d = 1'b1;
        end
        PLAY: if (hit_now) begin
          state_d = DEAD;
          cnt_d = '0;
          x_d = W'(X_START);
          y_d = W'(Y_START);
          wx_d = wx_rst;
          gy_d = gy_rst;
          gs_d = W'(GAP_INIT);
`ifdef WALL_SPEEDUP_EN
          spd_d = W'(WALL_STEP);
`endif
        end else begin
          x_d = px;
          y_d = py;
          wx_d = wx_mv;
          gy_d = gy_mv;
          gs_d = shrink ? gs_q - W'(GAP_DEC) : gs_q;
`ifdef WALL_SPEEDUP_EN
          spd_d = (shrink && spd_q < W'(2 * WALL_STEP)) ? spd_q + W'(1) : spd_q;
`endif
        end
        DEAD: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DEAD_TICKS - 1)) begin
            state_d = PLAY;
            clr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q <= W'(X_START);
      y_q <= W'(Y_START);
      wx_q <= wx_rst;
      gy_q <= gy_rst;
      gs_q <= W'(GAP_INIT);
      lfsr_q <= 16'hACE1;
      cnt_q <= '0;
      hit_q <= 1'b0;
      clr_q <= 1'b0;
`ifdef WALL_SPEEDUP_EN
      spd_q <= W'(WALL_STEP);
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      wx_q <= wx_d;
      gy_q <= gy_d;
      gs_q <= gs_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      clr_q <= clr_d;
`ifdef WALL_SPEEDUP_EN
      spd_q <= spd_d;
`endif
    end
  end
  for (genvar g = 0; g < N_WALLS; g++) begin : g_pack
    assign bus_io.wall_x[g*W +: W] = wx_q[g];
    assign bus_io.gap_y[g*W +: W] = gy_q[g];
  end
  assign bus_io.blk_x = x_q;
  assign bus_io.blk_y = y_q;
  assign bus_io.gap_size = gs_q;
  assign bus_io.stop = state_q != PLAY;
  assign bus_io.score_clr = clr_q;
  assign bus_io.state = state_q;
endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: vector table, corner sequences and a random run against a frame-level game model
module tb_obstacle_engine;
  localparam int N = 2;
  localparam int W = 11;
`ifdef WALL_SPEEDUP_EN
  localparam int EXP_STEP = 8;
`else
  localparam int EXP_STEP = 4;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;
  obstacle_engine_if #(.N_WALLS(N), .W(W)) ifc ();
  obstacle_engine_if #(.N_WALLS(N), .W(W)) ifc2 ();
  obstacle_engine #(.N_WALLS(N), .W(W)) dut (.clk(clk), .reset_n(reset_n), .bus_io(ifc));
  obstacle_engine #(.N_WALLS(N), .W(W), .SCREEN_W(2)) dut2 (.clk(clk), .reset_n(rst2), .bus_io(ifc2));

  int checks = 0;
  int failures = 0;

  int m_st, m_x, m_y, m_gs, m_spd, m_lfsr, m_cnt;
  int m_wx[N];
  int m_gy[N];
  bit m_lat, m_clr, m_ok;

  typedef struct {
    logic [4:0] b;
    logic       h;
    int         n;
    int         st;
    int         x;
    int         y;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [63:0] pk(input int lo, input int hi);
    return (64'(hi) << W) | 64'(lo);
  endfunction

  function automatic void m_home();
    m_x = 704;
    m_y = 435;
    for (int i = 0; i < N; i++) begin
      m_wx[i] = i * (1440 / N);
      m_gy[i] = 64 + i * 64;
    end
    m_gs = 150;
    m_spd = 4;
  endfunction

  function automatic void m_play();
    int wraps;
    if (ifc.btn_right && !ifc.btn_left && m_x < 1396) m_x += 3;
    else if (ifc.btn_left && !ifc.btn_right && m_x > 10) m_x -= 3;
    if (ifc.btn_down && !ifc.btn_up && m_y < 856) m_y += 3;
    else if (ifc.btn_up && !ifc.btn_down && m_y > 14) m_y -= 3;
    wraps = 0;
    for (int i = 0; i < N; i++) begin
      if (m_wx[i] + m_spd >= 1440) begin
        m_wx[i] = 0;
        m_gy[i] = 64 + (m_lfsr % 512);
        wraps++;
      end else m_wx[i] += m_spd;
    end
    if (wraps > 0 && m_gs > 45) begin
      m_gs -= 10;
`ifdef WALL_SPEEDUP_EN
      if (m_spd < 8) m_spd++;
`endif
    end
  endfunction

  function automatic void m_step();
    bit hn;
    int fb;
    if (!reset_n) begin
      m_home();
      m_st = 0;
      m_lfsr = 16'hACE1;
      m_cnt = 0;
      m_lat = 0;
      m_clr = 0;
      m_ok = 1;
    end else if (m_ok) begin
      hn = m_lat || ifc.hit;
      m_clr = 0;
      if (!ifc.tick) m_lat = hn;
      else begin
        m_lat = 0;
        if (m_st == 0 && ifc.btn_centre) begin
          m_st = 1;
          m_clr = 1;
        end else if (m_st == 1 && hn) begin
          m_st = 2;
          m_cnt = 0;
          m_home();
        end else if (m_st == 1) m_play();
        else if (m_st == 2) begin
          if (m_cnt == 399) begin
            m_st = 1;
            m_clr = 1;
          end
          m_cnt++;
        end
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr * 2) + fb) % 65536;
      end
    end
  endfunction

  task automatic m_cmp();
    logic [63:0] ew, eg;
    if (m_ok) begin
      ew = 0;
      eg = 0;
      for (int i = 0; i < N; i++) begin
        ew |= 64'(m_wx[i]) << (i * W);
        eg |= 64'(m_gy[i]) << (i * W);
      end
      chk("m_state", ifc.state, m_st);
      chk("m_blk", pk(ifc.blk_y, ifc.blk_x), pk(m_y, m_x));
      chk("m_wall_x", ifc.wall_x, ew);
      chk("m_gap_y", ifc.gap_y, eg);
      chk("m_gap_size", ifc.gap_size, m_gs);
      chk("m_stop_clr", {ifc.stop, ifc.score_clr}, {m_st != 1, m_clr});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    m_step();
    m_cmp();
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      ifc.tick = 1'b1;
      cyc();
      ifc.tick = 1'b0;
      cyc();
    end
  endtask

  task automatic tk2();
    ifc2.tick = 1'b1;
    cyc();
    ifc2.tick = 1'b0;
    cyc();
  endtask

  task automatic no_in();
    {ifc.tick, ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right, ifc.btn_centre, ifc.hit} = '0;
  endtask

  task automatic chk_home(input string nm);
    chk({nm, "_blk"}, pk(ifc.blk_y, ifc.blk_x), pk(435, 704));
    chk({nm, "_wall_x"}, ifc.wall_x, pk(0, 720));
    chk({nm, "_gap_y"}, ifc.gap_y, pk(64, 128));
    chk({nm, "_gap_size"}, ifc.gap_size, 150);
  endtask

  initial begin
    int k, prev;
    bit done;
    no_in();
    {ifc2.tick, ifc2.btn_up, ifc2.btn_down, ifc2.btn_left, ifc2.btn_right, ifc2.btn_centre, ifc2.hit} = '0;
    m_ok = 0;
    tbl[0] = '{5'b00000, 1'b0, 5, 0, 704, 435};
    tbl[1] = '{5'b00001, 1'b0, 1, 1, 704, 435};
    tbl[2] = '{5'b10000, 1'b0, 1, 1, 704, 432};
    tbl[3] = '{5'b11000, 1'b0, 3, 1, 704, 432};
    tbl[4] = '{5'b00100, 1'b0, 2, 1, 698, 432};
    tbl[5] = '{5'b00010, 1'b0, 4, 1, 710, 432};
    tbl[6] = '{5'b00110, 1'b0, 2, 1, 710, 432};
    tbl[7] = '{5'b01010, 1'b0, 1, 1, 713, 435};
    tbl[8] = '{5'b00000, 1'b1, 1, 2, 704, 435};
    tbl[9] = '{5'b10000, 1'b0, 10, 2, 704, 435};
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int r = 0; r < 10; r++) begin
      {ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right, ifc.btn_centre} = tbl[r].b;
      ifc.hit = tbl[r].h;
      tk(tbl[r].n);
      chk($sformatf("tbl%0d_state", r), ifc.state, tbl[r].st);
      chk($sformatf("tbl%0d_blk", r), pk(ifc.blk_y, ifc.blk_x), pk(tbl[r].y, tbl[r].x));
    end
    no_in();
    reset_n = 1'b0;
    ifc.tick = 1'b1;
    ifc.hit = 1'b1;
    cyc();
    no_in();
    reset_n = 1'b1;
    chk("rst_state", ifc.state, 0);
    chk_home("rst");
    chk("rst_stop_clr", {ifc.stop, ifc.score_clr}, 2'b10);
    tk(5);
    chk("idle_state", ifc.state, 0);
    chk_home("idle");
    chk("idle_stop", ifc.stop, 1);
    ifc.btn_centre = 1'b1;
    ifc.tick = 1'b1;
    cyc();
    chk("start_clr_on", ifc.score_clr, 1);
    chk("start_state", ifc.state, 1);
    no_in();
    cyc();
    chk("start_clr_off", ifc.score_clr, 0);
    chk("play_stop", ifc.stop, 0);
    tk(179);
    chk("wall1_pre", ifc.wall_x[2*W-1:W], 1436);
    tk(1);
    chk("wall1_wrap", ifc.wall_x[2*W-1:W], 0);
    chk("gap_dec1", ifc.gap_size, 140);
    prev = int'(ifc.wall_x[W-1:0]);
    done = 0;
    for (k = 0; k < 400 && !done; k++) begin
      tk(1);
      if (int'(ifc.wall_x[W-1:0]) < prev) done = 1;
      prev = int'(ifc.wall_x[W-1:0]);
    end
    chk("wall0_wrap_seen", done, 1);
    chk("wall0_wrap", ifc.wall_x[W-1:0], 0);
    chk("gap_dec2", ifc.gap_size, 130);
    ifc.btn_up = 1'b1;
    tk(150);
    chk("y_min_reach", ifc.blk_y, 12);
    tk(3);
    chk("y_min_hold", ifc.blk_y, 12);
    ifc.btn_up = 1'b0;
    ifc.btn_down = 1'b1;
    tk(300);
    chk("y_max_reach", ifc.blk_y, 858);
    ifc.btn_up = 1'b1;
    tk(2);
    chk("y_updown_hold", ifc.blk_y, 858);
    no_in();
    ifc.hit = 1'b1;
    cyc();
    ifc.hit = 1'b0;
    cyc();
    tk(1);
    chk("dead_state", ifc.state, 2);
    chk("dead_stop", ifc.stop, 1);
    chk_home("dead");
    tk(399);
    chk("dead_399_state", ifc.state, 2);
    ifc.tick = 1'b1;
    cyc();
    chk("respawn_clr_on", ifc.score_clr, 1);
    chk("respawn_state", ifc.state, 1);
    ifc.tick = 1'b0;
    cyc();
    chk("respawn_clr_off", ifc.score_clr, 0);
    tk(1200);
    done = 0;
    for (k = 0; k < 20 && !done; k++) begin
      prev = int'(ifc.wall_x[W-1:0]);
      tk(1);
      if (int'(ifc.wall_x[W-1:0]) > prev) begin
        chk("wall_step", int'(ifc.wall_x[W-1:0]) - prev, EXP_STEP);
        done = 1;
      end
    end
    chk("wall_step_seen", done, 1);
    ifc.hit = 1'b1;
    tk(1);
    ifc.hit = 1'b0;
    tk(200);
    chk("middead_state", ifc.state, 2);
    reset_n = 1'b0;
    ifc.tick = 1'b1;
    ifc.btn_centre = 1'b1;
    cyc();
    no_in();
    reset_n = 1'b1;
    chk("middead_rst_state", ifc.state, 0);
    chk_home("middead_rst");
    chk("middead_rst_stop_clr", {ifc.stop, ifc.score_clr}, 2'b10);
    cyc();
    chk("middead_after_clr", ifc.score_clr, 0);
    repeat (3000) begin
      reset_n = $urandom_range(0, 799) != 0;
      ifc.tick = $urandom_range(0, 2) == 0;
      {ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right} = 4'($urandom);
      ifc.btn_centre = $urandom_range(0, 3) == 0;
      ifc.hit = $urandom_range(0, 29) == 0;
      cyc();
    end
    reset_n = 1'b1;
    no_in();
    rst2 = 1'b0;
    cyc();
    rst2 = 1'b1;
    ifc2.btn_centre = 1'b1;
    tk2();
    ifc2.btn_centre = 1'b0;
    chk("dual_start", {ifc2.state, ifc2.gap_size}, {2'd1, 11'd150});
    tk2();
    chk("dual_wrap_gap", ifc2.gap_size, 140);
    tk2();
    chk("dual_wrap_gap2", ifc2.gap_size, 130);
    chk("dual_wall_x", ifc2.wall_x, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
